// File: rtl/lsu_controller.sv
// Load/store sequencer between the CPU memory stage and a word-addressed data memory.
// Aligns stores onto byte lanes, extracts/extends load data, and times out stuck accesses.
module lsu_controller #(
  parameter int DATA_WIDTH        = 32,
  parameter int RAM_ADDRESS_WIDTH = 28,
  parameter int TIMEOUT           = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [RAM_ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  output logic                         stall,
  output logic                         resp_valid,
  output logic [DATA_WIDTH-1:0]        resp_rdata,
  output logic                         resp_err,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [RAM_ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]                   mem_be,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         mem_ack
);
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [7:0] TMO     = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic                         write;
    logic [RAM_ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]        wdata;
    logic [1:0]                   size;
    logic                         unsgn;
  } req_t;

  state_t                  state, state_n;
  req_t                    req_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [7:0]              cnt;
  logic                    bad_req;
  logic                    active;
  logic [3:0]              be;
  logic [15:0]             rd_lane;
  logic [DATA_WIDTH-1:0]   wdata_rep;
  logic [DATA_WIDTH-1:0]   ld_data;

  always_comb begin
    case (req_size)
      SZ_WORD: bad_req = req_addr[1:0] != 2'b00;
      SZ_HALF: bad_req = req_addr[0];
      SZ_BYTE: bad_req = 1'b0;
      default: bad_req = 1'b1;
    endcase
  end

  // Lane steering is driven from the captured request so it stays stable through WAIT.
  always_comb begin
    rd_lane = 16'(mem_rdata >> {req_q.addr[1:0], 3'b000});
    case (req_q.size)
      SZ_BYTE: begin
        be        = 4'b0001 << req_q.addr[1:0];
        wdata_rep = {4{req_q.wdata[7:0]}};
        ld_data   = {{(DATA_WIDTH-8){~req_q.unsgn & rd_lane[7]}}, rd_lane[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << req_q.addr[1:0];
        wdata_rep = {2{req_q.wdata[15:0]}};
        ld_data   = {{(DATA_WIDTH-16){~req_q.unsgn & rd_lane[15]}}, rd_lane[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = req_q.wdata;
        ld_data   = mem_rdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req_valid) state_n = bad_req ? S_DONE : S_ISSUE;
      S_ISSUE: state_n = mem_ack ? S_DONE : S_WAIT;
      S_WAIT:  if (mem_ack || cnt == TMO) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_q   <= '{write: req_write, addr: req_addr, wdata: req_wdata,
                       size: req_size, unsgn: req_unsigned};
          err_q   <= bad_req;
          rdata_q <= '0;
          cnt     <= '0;
        end
        S_ISSUE: begin
          if (mem_ack) rdata_q <= req_q.write ? '0 : ld_data;
          else         cnt     <= 8'd1;
        end
        S_WAIT: begin
          // An ack arriving on the expiry cycle wins over the timeout.
          if (mem_ack)         rdata_q <= req_q.write ? '0 : ld_data;
          else if (cnt == TMO) err_q   <= 1'b1;
          else                 cnt     <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active     = (state == S_ISSUE) || (state == S_WAIT);
    req_ready  = (state == S_IDLE);
    stall      = (state != S_IDLE) || req_valid;
    mem_en     = (state == S_ISSUE);
    mem_we     = active & req_q.write;
    mem_addr   = active ? {req_q.addr[RAM_ADDRESS_WIDTH-1:2], 2'b00} : '0;
    mem_be     = active ? be : 4'b0000;
    mem_wdata  = active ? wdata_rep : '0;
    resp_valid = (state == S_DONE);
    resp_err   = (state == S_DONE) & err_q;
    resp_rdata = (state == S_DONE) ? rdata_q : '0;
  end
endmodule
